// File: rtl/memory_bank_writer.sv
// memory_bank_writer: writes packed words from the DRAM packer into a
// ping-pong (two-bank) BRAM, publishes per-bank full flags to the compute
// side and drops words, with a sticky overflow flag, while no bank is free.
module memory_bank_writer #(
  parameter int DATA_BITWIDTH = 163,
  parameter int ADDR_BITWIDTH = 10
) (
  input  logic                     clk_i,
  input  logic                     mem_wr_rst_i,
  input  logic [DATA_BITWIDTH-1:0] data_in_i,
  input  logic                     data_write_enable_i,
  input  logic                     start_i,
  input  logic [ADDR_BITWIDTH:0]   load_words_i,
  input  logic [1:0]               bank_release_i,
  output logic                     bram_we_o,
  output logic [ADDR_BITWIDTH:0]   bram_addr_o,
  output logic [DATA_BITWIDTH-1:0] bram_data_o,
  output logic [1:0]               bank_full_o,
  output logic                     busy_o,
  output logic                     overflow_o
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT_BANK
  } state_t;

  // Largest load that fits one bank; larger requests are clamped to this.
  localparam logic [ADDR_BITWIDTH:0]   MAX_WORDS = {1'b1, {ADDR_BITWIDTH{1'b0}}};
  localparam logic [ADDR_BITWIDTH:0]   WORDS_ONE = (ADDR_BITWIDTH+1)'(1);
  localparam logic [ADDR_BITWIDTH-1:0] CNT_ONE   = ADDR_BITWIDTH'(1);

  state_t                   state_q;
  state_t                   state_d;
  logic [ADDR_BITWIDTH:0]   words_q;
  logic [ADDR_BITWIDTH-1:0] word_cnt_q;
  logic                     wr_bank_q;

  logic                     start_ok;
  logic [ADDR_BITWIDTH:0]   load_clamped;
  logic                     accept;
  logic                     last_word;
  logic                     complete;
  logic                     next_bank;
  logic                     next_bank_free;
  logic [1:0]               set_mask;

  // A zero-length load is meaningless, so such a start is simply ignored.
  assign start_ok       = start_i && (load_words_i != '0);
  assign load_clamped   = (load_words_i > MAX_WORDS) ? MAX_WORDS : load_words_i;
  // Words are only ever taken while filling; no backpressure exists upstream.
  assign accept         = (state_q == FILL) && data_write_enable_i;
  assign last_word      = ({1'b0, word_cnt_q} == (words_q - WORDS_ONE));
  assign complete       = accept && last_word;
  assign next_bank      = ~wr_bank_q;
  // A release arriving together with the completion already frees the bank.
  assign next_bank_free = !bank_full_o[next_bank] || bank_release_i[next_bank];
  assign set_mask       = complete ? (wr_bank_q ? 2'b10 : 2'b01) : 2'b00;

  // State register.
  always_ff @(posedge clk_i) begin
    if (mem_wr_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fill until both banks are full, then wait for a release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = FILL;
      end
      FILL: begin
        if (complete) state_d = next_bank_free ? FILL : WAIT_BANK;
      end
      WAIT_BANK: begin
        if (bank_release_i[wr_bank_q] && bank_full_o[wr_bank_q]) state_d = FILL;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: busy whenever a load session is active.
  always_comb begin
    busy_o = 1'b0;
    if ((state_q == FILL) || (state_q == WAIT_BANK)) busy_o = 1'b1;
  end

  // Datapath: BRAM write port, address counters, bank flags and overflow.
  always_ff @(posedge clk_i) begin
    if (mem_wr_rst_i) begin
      bram_we_o   <= 1'b0;
      bram_addr_o <= '0;
      bram_data_o <= '0;
      bank_full_o <= 2'b00;
      overflow_o  <= 1'b0;
      words_q     <= '0;
      word_cnt_q  <= '0;
      wr_bank_q   <= 1'b0;
    end else begin
      bram_we_o <= accept;
      if (accept) begin
        bram_data_o <= data_in_i;
        bram_addr_o <= {wr_bank_q, word_cnt_q};
        if (last_word) begin
          word_cnt_q <= '0;
          wr_bank_q  <= ~wr_bank_q;
        end else begin
          word_cnt_q <= word_cnt_q + CNT_ONE;
        end
      end
      if ((state_q == IDLE) && start_ok) begin
        words_q    <= load_clamped;
        word_cnt_q <= '0;
        wr_bank_q  <= 1'b0;
      end
      if ((state_q == WAIT_BANK) && data_write_enable_i) begin
        overflow_o <= 1'b1;
      end
      bank_full_o <= (bank_full_o & ~bank_release_i) | set_mask;
    end
  end

endmodule
